cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among NUM_FU functional units that finish in the same cycle.
- Grants at most one FU per cycle, using round-robin priority.
- Registers the winning result and broadcasts it one cycle later to the ROB and the reservation stations.
- Sits between the FU outputs and the ROB write port (fu_done/fu_value/fu_rob_idx/fu_set_nzcv/fu_nzcv).

Parameters:
NUM_FU, 4, number of requesting functional units (2..8)
GPR_SIZE, 64, result value width
ROB_IDX_SIZE, 4, ROB index width
FU_IDX_SIZE, 2, width of the round-robin pointer; equals clog2(NUM_FU)

Ports:
in_clk  input  1  clock, rising edge
in_rst  input  1  asynchronous, active-high reset
in_fu_done  input  NUM_FU  per-FU result-valid request
in_fu_value  input  NUM_FU*GPR_SIZE  packed results; FU i occupies [i*GPR_SIZE +: GPR_SIZE]
in_fu_rob_idx  input  NUM_FU*ROB_IDX_SIZE  packed destination ROB indices
in_fu_set_nzcv  input  NUM_FU  per-FU flag-write request
in_fu_nzcv  input  NUM_FU*4  packed NZCV values
in_cdb_stall  input  1  consumer cannot accept a new broadcast; hold the CDB
in_flush  input  1  mispredict flush; squash the pending broadcast
out_fu_grant  output  NUM_FU  one-hot grant, combinational
out_cdb_valid  output  1  broadcast valid
out_cdb_value  output  GPR_SIZE  broadcast value
out_cdb_rob_idx  output  ROB_IDX_SIZE  broadcast ROB index
out_cdb_set_nzcv  output  1  broadcast flag-write
out_cdb_nzcv  output  4  broadcast NZCV
out_fu_idx  output  FU_IDX_SIZE  index of the FU that owns the current broadcast

Behaviour:
- Reset (asynchronous, active-high):
  - out_cdb_valid=0; value, rob_idx, set_nzcv, nzcv and out_fu_idx all 0.
  - rr_ptr=0.
  - out_fu_grant=0 while in_rst is high.
- Handshake:
  - FU i holds in_fu_done[i] and its payload stable until a cycle where out_fu_grant[i]=1.
  - Transfer happens on the rising edge of that cycle.
  - The FU may present a new result in the next cycle.
- Grant selection (combinational):
  - Scan FUs starting at rr_ptr, wrapping modulo NUM_FU.
  - The first i with in_fu_done[i]=1 wins.
  - out_fu_grant is one-hot or zero.
  - Grant is forced to zero when in_cdb_stall=1 or in_flush=1.
- Output register load: when in_cdb_stall=0 and in_flush=0, on each edge:
  - out_cdb_valid <= |grant.
  - If a grant exists, payload and out_fu_idx are loaded from the winner.
  - If no grant, the payload registers hold their old values; they are don't-care while valid=0.
- Latency: exactly 1 cycle from the grant edge to the broadcast.
  - Back-to-back broadcasts are possible every cycle.
- Pointer: on a granted transfer, rr_ptr <= (winner+1) mod NUM_FU. Otherwise rr_ptr is unchanged.
  - Wrap-around follows modulo NUM_FU, including non-power-of-2 NUM_FU.
- Stall (in_cdb_stall=1, in_flush=0):
  - All output registers hold; no grant; rr_ptr holds.
  - Requesters keep waiting.
- Flush (synchronous, has priority over stall):
  - out_cdb_valid <= 0 on the next edge; no grant; rr_ptr unchanged.
  - Requests that are still pending are not dropped by the arbiter. The FUs clear their own in_fu_done.
- Fairness: a continuously requesting FU is granted within NUM_FU non-stalled, non-flushed cycles.
- Simultaneous requests: exactly one FU wins per cycle. The others see grant=0 and retry in later cycles.
- Reset asserted mid-operation: outputs clear immediately, without waiting for a clock edge. Any broadcast in flight is lost.
- Flag handling: out_cdb_set_nzcv is copied from the winner. out_cdb_nzcv is meaningful only when set_nzcv=1.

Test Plan:
- Reset then idle: assert in_rst mid-cycle -> out_cdb_valid=0 and rr_ptr=0 immediately; with all done=0, no grants and valid stays 0.
- Single request: FU2 done, value=0xDEAD, rob_idx=5, set_nzcv=1, nzcv=4'b0100 -> grant=4'b0100 that cycle; next cycle valid=1, value=0xDEAD, rob_idx=5, nzcv=0100, fu_idx=2; rr_ptr=3.
- Four FUs request continuously from rr_ptr=0 -> grants go 0,1,2,3,0 on consecutive cycles; broadcasts follow one cycle later with matching rob_idx.
- Stall: FU1 broadcast valid, assert in_cdb_stall for 3 cycles while FU0 and FU3 request -> outputs hold FU1 data, grant=0; after release, FU3 is granted before FU0 (rr_ptr=2).
- Flush alongside stall and a request: in_flush=1, in_cdb_stall=1, FU0 done -> next edge valid=0, grant=0, rr_ptr unchanged; once flush drops, FU0 is granted.
- Wrap-around with NUM_FU=3, rr_ptr=2: FU0 and FU1 request -> FU0 granted and rr_ptr=1; next cycle FU1 granted and rr_ptr=2.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among finishing FUs,
// winner registered and broadcast to the ROB and reservation stations.
module cdb_arbiter #(
  parameter int NUM_FU       = 4,
  parameter int GPR_SIZE     = 64,
  parameter int ROB_IDX_SIZE = 4,
  parameter int FU_IDX_SIZE  = 2
) (
  input  logic                           in_clk,
  input  logic                           in_rst,
  input  logic [NUM_FU-1:0]              in_fu_done,
  input  logic [NUM_FU*GPR_SIZE-1:0]     in_fu_value,
  input  logic [NUM_FU*ROB_IDX_SIZE-1:0] in_fu_rob_idx,
  input  logic [NUM_FU-1:0]              in_fu_set_nzcv,
  input  logic [NUM_FU*4-1:0]            in_fu_nzcv,
  input  logic                           in_cdb_stall,
  input  logic                           in_flush,
  output logic [NUM_FU-1:0]              out_fu_grant,
  output logic                           out_cdb_valid,
  output logic [GPR_SIZE-1:0]            out_cdb_value,
  output logic [ROB_IDX_SIZE-1:0]        out_cdb_rob_idx,
  output logic                           out_cdb_set_nzcv,
  output logic [3:0]                     out_cdb_nzcv,
  output logic [FU_IDX_SIZE-1:0]         out_fu_idx
);

  localparam int PW = FU_IDX_SIZE + 1;

  logic [FU_IDX_SIZE-1:0] rr_ptr;
  logic [FU_IDX_SIZE-1:0] win;
  logic [FU_IDX_SIZE-1:0] sel;
  logic [FU_IDX_SIZE-1:0] nxt_ptr;
  logic [PW-1:0]          idx;
  logic                   found;
  logic                   go;

  // Scan from rr_ptr with explicit modulo so non-power-of-2 counts wrap
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    sel   = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = {1'b0, rr_ptr} + PW'(k);
      if (idx >= PW'(NUM_FU))
        idx = idx - PW'(NUM_FU);
      sel = idx[FU_IDX_SIZE-1:0];
      if (!found && in_fu_done[sel]) begin
        found = 1'b1;
        win   = sel;
      end
    end
  end

  assign go = found & ~in_cdb_stall & ~in_flush & ~in_rst;

  assign out_fu_grant = go ? (NUM_FU'(1) << win) : '0;

  assign nxt_ptr = (win == FU_IDX_SIZE'(NUM_FU - 1)) ?
                   '0 : win + 1'b1;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      rr_ptr           <= '0;
      out_cdb_valid    <= 1'b0;
      out_cdb_value    <= '0;
      out_cdb_rob_idx  <= '0;
      out_cdb_set_nzcv <= 1'b0;
      out_cdb_nzcv     <= '0;
      out_fu_idx       <= '0;
    end else if (in_flush) begin
      out_cdb_valid <= 1'b0;
    end else if (!in_cdb_stall) begin
      out_cdb_valid <= go;
      if (go) begin
        rr_ptr           <= nxt_ptr;
        out_cdb_value    <= in_fu_value[win*GPR_SIZE +: GPR_SIZE];
        out_cdb_rob_idx  <= in_fu_rob_idx[win*ROB_IDX_SIZE +: ROB_IDX_SIZE];
        out_cdb_set_nzcv <= in_fu_set_nzcv[win];
        out_cdb_nzcv     <= in_fu_nzcv[win*4 +: 4];
        out_fu_idx       <= win;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter against a
// round-robin reference model; a 3-FU instance covers odd wrap-around.
module tb_cdb_arbiter;

  localparam int N = 4;
  localparam int G = 64;
  localparam int R = 4;
  localparam int F = 2;

  logic clk = 1'b0;
  logic rst, stall, flush;
  logic [N-1:0]   done, setf, grant;
  logic [N*G-1:0] value;
  logic [N*R-1:0] rob;
  logic [N*4-1:0] nzcv;
  logic           cvalid, cset;
  logic [G-1:0]   cvalue;
  logic [R-1:0]   crob;
  logic [3:0]     cnzcv;
  logic [F-1:0]   cidx;

  logic [2:0]   d3, s3, g3;
  logic [3*G-1:0] v3;
  logic [3*R-1:0] r3;
  logic [11:0]  n3;
  logic         cv3, cs3;
  logic [G-1:0] cval3;
  logic [R-1:0] crob3;
  logic [3:0]   cn3;
  logic [1:0]   ci3;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_FU(N), .GPR_SIZE(G), .ROB_IDX_SIZE(R),
                .FU_IDX_SIZE(F)) dut (
    .in_clk(clk), .in_rst(rst), .in_fu_done(done),
    .in_fu_value(value), .in_fu_rob_idx(rob),
    .in_fu_set_nzcv(setf), .in_fu_nzcv(nzcv),
    .in_cdb_stall(stall), .in_flush(flush),
    .out_fu_grant(grant), .out_cdb_valid(cvalid),
    .out_cdb_value(cvalue), .out_cdb_rob_idx(crob),
    .out_cdb_set_nzcv(cset), .out_cdb_nzcv(cnzcv),
    .out_fu_idx(cidx));

  cdb_arbiter #(.NUM_FU(3), .GPR_SIZE(G), .ROB_IDX_SIZE(R),
                .FU_IDX_SIZE(2)) dut3 (
    .in_clk(clk), .in_rst(rst), .in_fu_done(d3),
    .in_fu_value(v3), .in_fu_rob_idx(r3),
    .in_fu_set_nzcv(s3), .in_fu_nzcv(n3),
    .in_cdb_stall(stall), .in_flush(flush),
    .out_fu_grant(g3), .out_cdb_valid(cv3),
    .out_cdb_value(cval3), .out_cdb_rob_idx(crob3),
    .out_cdb_set_nzcv(cs3), .out_cdb_nzcv(cn3),
    .out_fu_idx(ci3));

  int errs = 0;
  int checks = 0;

  int           m_ptr;
  bit           m_valid;
  logic [G-1:0] m_value;
  logic [R-1:0] m_rob;
  logic         m_set;
  logic [3:0]   m_nzcv;
  int           m_idx;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_value = '0;
    m_rob = '0; m_set = 0; m_nzcv = '0; m_idx = 0;
  endtask

  task automatic present(int i, logic [G-1:0] v, logic [R-1:0] r,
                         logic s, logic [3:0] n);
    done[i] = 1'b1;
    value[i*G +: G] = v;
    rob[i*R +: R] = r;
    setf[i] = s;
    nzcv[i*4 +: 4] = n;
  endtask

  task automatic present_rand(int i);
    present(i, {$urandom, $urandom}, R'($urandom), 1'($urandom),
            4'($urandom));
  endtask

  // Requests are served by scanning forward from the pointer, modulo N
  function automatic int pick();
    for (int k = 0; k < N; k++)
      if (done[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  // Called at negedge with inputs driven; returns the winner or -1
  task automatic step(input bit refill, output int w);
    logic [N-1:0] eg;
    logic [G-1:0] pv;
    logic [R-1:0] pr;
    logic         ps;
    logic [3:0]   pn;
    #1;
    w = (stall || flush) ? -1 : pick();
    eg = '0;
    if (w >= 0) begin
      eg[w] = 1'b1;
      pv = value[w*G +: G]; pr = rob[w*R +: R];
      ps = setf[w]; pn = nzcv[w*4 +: 4];
    end
    chk("grant", 64'(grant), 64'(eg));
    @(posedge clk);
    if (flush) m_valid = 0;
    else if (!stall) begin
      m_valid = (w >= 0);
      if (w >= 0) begin
        m_value = pv; m_rob = pr; m_set = ps; m_nzcv = pn;
        m_idx = w; m_ptr = (w + 1) % N;
      end
    end
    #1;
    chk("valid", 64'(cvalid), 64'(m_valid));
    if (m_valid) begin
      chk("value", cvalue, m_value);
      chk("rob_idx", 64'(crob), 64'(m_rob));
      chk("set_nzcv", 64'(cset), 64'(m_set));
      if (m_set) chk("nzcv", 64'(cnzcv), 64'(m_nzcv));
      chk("fu_idx", 64'(cidx), 64'(m_idx));
    end
    chk("rr_ptr", 64'(dut.rr_ptr), 64'(m_ptr));
    if (w >= 0) begin
      done[w] = 1'b0;
      if (refill) present_rand(w);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_valid", 64'(cvalid), 64'd0);
    chk("rst_ptr", 64'(dut.rr_ptr), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int w;
    rst = 1'b1; stall = 0; flush = 0;
    done = '0; setf = '0; value = '0; rob = '0; nzcv = '0;
    d3 = '0; s3 = '0; v3 = '0; r3 = '0; n3 = '0;
    model_reset();
    #2;
    chk("rst_valid0", 64'(cvalid), 64'd0);
    chk("rst_value0", cvalue, 64'd0);
    chk("rst_idx0", 64'(cidx), 64'd0);
    done = 4'b1111;
    #1;
    chk("rst_grant0", 64'(grant), 64'd0);
    done = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(0, w);

    present(2, 64'hDEAD, 4'd5, 1'b1, 4'b0100);
    step(0, w);
    chk("single_w", 64'(w), 64'd2);
    chk("single_val", cvalue, 64'hDEAD);
    chk("single_ptr", 64'(dut.rr_ptr), 64'd3);

    do_reset();
    for (int i = 0; i < N; i++) present_rand(i);
    for (int k = 0; k < 5; k++) begin
      step(1, w);
      chk("rr_order", 64'(w), 64'(k % N));
    end
    done = '0;
    step(0, w);

    do_reset();
    present_rand(1);
    step(0, w);
    present_rand(0); present_rand(3);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(0, w);
      chk("stall_hold", 64'(cidx), 64'd1);
    end
    stall = 1'b0;
    step(0, w);
    chk("post_stall", 64'(w), 64'd3);

    flush = 1'b1; stall = 1'b1;
    step(0, w);
    chk("flush_valid", 64'(cvalid), 64'd0);
    flush = 1'b0; stall = 1'b0;
    step(0, w);
    chk("post_flush", 64'(w), 64'd0);

    present_rand(2);
    step(0, w);
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_valid", 64'(cvalid), 64'd0);
    chk("async_ptr", 64'(dut.rr_ptr), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    done = '0;

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!done[i] && $urandom_range(99) < 40) present_rand(i);
      stall = ($urandom_range(99) < 15);
      flush = ($urandom_range(99) < 8);
      step($urandom_range(1), w);
    end
    stall = 0; flush = 0; done = '0;

    @(negedge clk);
    d3 = 3'b010;
    #1 chk("w3_g1", 64'(g3), 64'b010);
    @(posedge clk);
    #1 chk("w3_p1", 64'(dut3.rr_ptr), 64'd2);
    d3 = 3'b011;
    @(negedge clk);
    #1 chk("w3_g2", 64'(g3), 64'b001);
    @(posedge clk);
    #1 chk("w3_p2", 64'(dut3.rr_ptr), 64'd1);
    chk("w3_idx2", 64'(ci3), 64'd0);
    d3 = 3'b010;
    @(negedge clk);
    #1 chk("w3_g3", 64'(g3), 64'b010);
    @(posedge clk);
    #1 chk("w3_p3", 64'(dut3.rr_ptr), 64'd2);
    chk("w3_valid3", 64'(cv3), 64'd1);
    d3 = '0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
